// File: rtl/m_add_add_wrapper_if.sv
// Stream bundle for the quadtree (A + B) + C accelerator: operand words in, result root pointer out.
interface m_add_add_wrapper_if;
  logic [66:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic        o_tready;
  logic [16:0] o_tdata;

  modport master (output i_tdata, i_tlast, i_tvalid, o_tready, input i_tready, o_tdata);
  modport slave  (input i_tdata, i_tlast, i_tvalid, o_tready, output i_tready, o_tdata);
endinterface

// File: rtl/m_add_add_wrapper.sv
// Boolean quadtree R = (A + B) + C: loads three trees, walks them depth-first with an
// explicit frame stack, writes the result tree to res_mem in postorder and reports its root.
module m_add_add_wrapper #(
  parameter int DEPTH       = 1024,
  parameter int RES_DEPTH   = 4096,
  parameter int STACK_DEPTH = 32
) (
  input  logic               aclk,
  input  logic               areset,
  m_add_add_wrapper_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RES_DEPTH);
  localparam int SW = $clog2(STACK_DEPTH);
  localparam logic [1:0] Q_NONE = 2'd0, Q_VAL = 2'd1, Q_NODE = 2'd2;

  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_C, C_RD, C_EV, C_NX, C_PU, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0]    pa, pb, pc;
    logic             na, nb, nc;
    logic [2:0]       cc;
    logic [3:0][15:0] cp;
    logic [3:0][1:0]  ct;
  } frame_t;

  state_t        state, state_nxt;
  logic [66:0]   mem_a [DEPTH];
  logic [66:0]   mem_b [DEPTH];
  logic [66:0]   mem_c [DEPTH];
  logic [66:0]   res_mem [RES_DEPTH];
  frame_t        stk [STACK_DEPTH];
  logic [66:0]   rd_a, rd_b, rd_c;
  logic [AW:0]   ld_cnt;
  logic          ld_err, ld_acc, ld_fit;
  logic [SW-1:0] sp, sp_inc, sp_dec;
  logic [RW:0]   wp;
  logic          res_full;
  logic [16:0]   o_q;
  frame_t        cur, child, par;
  logic [1:0]    ta, tb, tc, ck;
  logic          any_val, any_node, all_none, all_val;
  logic          res_we, ret, push, fail, start;
  logic [66:0]   res_wd;

  // QVal 0 and QError behave exactly like QNone
  function automatic logic [1:0] norm(input logic [2:0] w, input logic none);
    if (none)                    return Q_NONE;
    if (w[1:0] == Q_NODE)        return Q_NODE;
    if (w[1:0] == Q_VAL && w[2]) return Q_VAL;
    return Q_NONE;
  endfunction

  function automatic logic [15:0] kid(input logic [66:0] w, input logic [1:0] k);
    return w[3 + 16*k +: 16];
  endfunction

  assign s.i_tready = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_C);
  assign s.o_tdata  = o_q;
  assign ld_acc     = s.i_tvalid && s.i_tready;
  assign ld_fit     = ld_cnt < (AW+1)'(DEPTH);
  assign res_full   = wp == (RW+1)'(RES_DEPTH);
  assign sp_inc     = sp + SW'(1);
  assign sp_dec     = sp - SW'(1);
  assign cur        = stk[sp];
  assign ck         = cur.cc[1:0];

  assign ta       = norm(rd_a[2:0], cur.na);
  assign tb       = norm(rd_b[2:0], cur.nb);
  assign tc       = norm(rd_c[2:0], cur.nc);
  assign any_val  = (ta == Q_VAL) || (tb == Q_VAL) || (tc == Q_VAL);
  assign any_node = (ta == Q_NODE) || (tb == Q_NODE) || (tc == Q_NODE);
  assign all_none = cur.ct == {4{Q_NONE}};
  assign all_val  = cur.ct == {4{Q_VAL}};
  assign start    = (state == LOAD_C) && (state_nxt == C_RD);

  always_ff @(posedge aclk) begin
    if (areset) state <= LOAD_A;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    res_we    = 1'b0;
    res_wd    = '0;
    ret       = 1'b0;
    push      = 1'b0;
    fail      = 1'b0;
    case (state)
      LOAD_A: if (ld_acc && s.i_tlast) state_nxt = LOAD_B;
      LOAD_B: if (ld_acc && s.i_tlast) state_nxt = LOAD_C;
      LOAD_C: if (ld_acc && s.i_tlast) begin
        if (ld_err || !ld_fit) begin
          fail      = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = C_RD;
        end
      end
      C_RD: state_nxt = C_EV;
      C_EV: begin
        if (any_node && !any_val) state_nxt = C_NX;
        else begin
          ret    = 1'b1;
          res_wd = {64'b0, any_val, any_val ? Q_VAL : Q_NONE};
        end
      end
      C_NX: begin
        if (cur.cc == 3'd4) begin
          ret = 1'b1;
          if (all_none)     res_wd = '0;
          else if (all_val) res_wd = {64'b0, 1'b1, Q_VAL};
          else              res_wd = {cur.cp, 1'b0, Q_NODE};
        end else begin
          state_nxt = C_PU;
        end
      end
      C_PU: begin
        if (sp == SW'(STACK_DEPTH-1)) begin
          fail      = 1'b1;
          state_nxt = DONE;
        end else begin
          push      = 1'b1;
          state_nxt = C_RD;
        end
      end
      DONE:    if (s.o_tready) state_nxt = LOAD_A;
      default: state_nxt = LOAD_A;
    endcase
    // every finished frame writes one result node, then returns to its parent (or ends)
    if (ret) begin
      if (res_full) begin
        ret       = 1'b0;
        fail      = 1'b1;
        state_nxt = DONE;
      end else begin
        res_we    = 1'b1;
        state_nxt = (sp == '0) ? DONE : C_NX;
      end
    end
  end

  // rd_x holds the parent words during C_PU, so child pointers come straight from them
  always_comb begin
    child    = '0;
    child.pa = AW'(kid(rd_a, ck));
    child.pb = AW'(kid(rd_b, ck));
    child.pc = AW'(kid(rd_c, ck));
    child.na = cur.na || (rd_a[1:0] != Q_NODE);
    child.nb = cur.nb || (rd_b[1:0] != Q_NODE);
    child.nc = cur.nc || (rd_c[1:0] != Q_NODE);
    par                = stk[sp_dec];
    par.cp[par.cc[1:0]] = 16'(wp);
    par.ct[par.cc[1:0]] = res_wd[1:0];
    par.cc             = par.cc + 3'd1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ld_cnt <= '0;
      ld_err <= 1'b0;
      sp     <= '0;
      wp     <= '0;
      o_q    <= '0;
    end else begin
      if (ld_acc) begin
        if (!ld_fit) ld_err <= 1'b1;
        ld_cnt <= s.i_tlast ? '0 : (ld_fit ? ld_cnt + 1'b1 : ld_cnt);
      end
      if (start) begin
        stk[0] <= '0;
        sp     <= '0;
        wp     <= '0;
      end
      if (push) begin
        stk[sp_inc] <= child;
        sp          <= sp_inc;
      end
      if (ret) begin
        wp <= wp + 1'b1;
        if (sp == '0) o_q <= {16'(wp), 1'b1};
        else begin
          stk[sp_dec] <= par;
          sp          <= sp_dec;
        end
      end
      if (fail) o_q <= {16'hFFFF, 1'b1};
      if (state == DONE && s.o_tready) begin
        o_q    <= '0;
        sp     <= '0;
        wp     <= '0;
        ld_cnt <= '0;
        ld_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (ld_acc && ld_fit) begin
      case (state)
        LOAD_A:  mem_a[ld_cnt[AW-1:0]] <= s.i_tdata;
        LOAD_B:  mem_b[ld_cnt[AW-1:0]] <= s.i_tdata;
        LOAD_C:  mem_c[ld_cnt[AW-1:0]] <= s.i_tdata;
        default: ;
      endcase
    end
    if (res_we) res_mem[wp[RW-1:0]] <= res_wd;
    rd_a <= mem_a[cur.pa];
    rd_b <= mem_b[cur.pb];
    rd_c <= mem_c[cur.pc];
  end
endmodule

// File: tb/tb_m_add_add_wrapper.sv
// Bench for m_add_add_wrapper: vector table of hand-derived trees plus reset/overflow sequences.
module tb_m_add_add_wrapper;
  logic clk = 1'b0;
  logic areset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [16:0] sb_q [$];

  m_add_add_wrapper_if bus ();
  m_add_add_wrapper dut (.aclk(clk), .areset(areset), .s(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0][66:0] a, b, c;
    int               la, lb, lc;
    int               gap;
    int               frames;
    logic [16:0]      exp_o;
    int               nres;
    logic [4:0][66:0] res;
  } vec_t;

  vec_t vecs [8];

  localparam logic [66:0] QN  = 67'd0;
  localparam logic [66:0] QV1 = {64'd0, 1'b1, 2'd1};
  localparam logic [66:0] QV0 = {64'd0, 1'b0, 2'd1};
  localparam logic [66:0] QER = {64'd0, 1'b1, 2'd3};

  function automatic logic [66:0] node(input logic [15:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0, 1'b0, 2'd2};
  endfunction

  function automatic logic [4:0][66:0] mk5(input logic [66:0] w0, w1, w2, w3, w4);
    logic [4:0][66:0] r;
    r[0] = w0; r[1] = w1; r[2] = w2; r[3] = w3; r[4] = w4;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [66:0] w, input logic last);
    int n = 0;
    bus.i_tdata  = w;
    bus.i_tlast  = last;
    bus.i_tvalid = 1'b1;
    while (!bus.i_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
  endtask

  task automatic load_tree(input logic [4:0][66:0] t, input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      send(t[i], i == len - 1);
      if (gap > 0 && i < len - 1) repeat ($urandom_range(1, gap)) @(negedge clk);
    end
  endtask

  // junk is offered on the input while busy; none of it may be accepted
  task automatic wait_done(input string nm, input int frames);
    int n = 0;
    logic rdy_seen = 1'b0;
    bus.i_tdata  = {67{1'b1}};
    bus.i_tlast  = 1'b1;
    bus.i_tvalid = 1'b1;
    while (!bus.o_tdata[0] && n < 400) begin
      if (bus.i_tready) rdy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
    chk({nm, ".busy_rdy"}, rdy_seen, 1'b0);
    chk({nm, ".latency_ok"}, n <= 4 * frames + 2, 1'b1);
  endtask

  task automatic ack(input string nm);
    bus.o_tready = 1'b1;
    @(negedge clk);
    bus.o_tready = 1'b0;
    chk({nm, ".ack_o"}, bus.o_tdata, 67'd0);
    chk({nm, ".ack_rdy"}, bus.i_tready, 67'd1);
  endtask

  task automatic finish_vec(input string nm, input int frames, input int nres, input logic [4:0][66:0] res);
    logic [16:0] e;
    wait_done(nm, frames);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 17'h0;
    chk({nm, ".o"}, bus.o_tdata, e);
    for (int i = 0; i < nres; i++) chk($sformatf("%s.res%0d", nm, i), dut.res_mem[i], res[i]);
    repeat (2) @(negedge clk);
    chk({nm, ".hold"}, bus.o_tdata, e);
    ack(nm);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    sb_q.push_back(v.exp_o);
    load_tree(v.a, v.la, v.gap);
    load_tree(v.b, v.lb, v.gap);
    load_tree(v.c, v.lc, v.gap);
    finish_vec(nm, v.frames, v.nres, v.res);
  endtask

  initial begin
    vecs[0] = '{a: mk5(QV1,QN,QN,QN,QN), b: mk5(QN,QN,QN,QN,QN), c: mk5(QN,QN,QN,QN,QN),
                la: 1, lb: 1, lc: 1, gap: 0, frames: 1, exp_o: 17'h00001, nres: 1,
                res: mk5(QV1,QN,QN,QN,QN)};
    vecs[1] = '{a: mk5(QN,QN,QN,QN,QN), b: mk5(QN,QN,QN,QN,QN), c: mk5(QN,QN,QN,QN,QN),
                la: 1, lb: 1, lc: 1, gap: 0, frames: 1, exp_o: 17'h00001, nres: 1,
                res: mk5(QN,QN,QN,QN,QN)};
    vecs[2] = '{a: mk5(node(1,2,3,4),QV1,QN,QN,QN), b: mk5(QN,QN,QN,QN,QN),
                c: mk5(node(1,2,3,4),QN,QN,QN,QV1),
                la: 5, lb: 1, lc: 5, gap: 0, frames: 5, exp_o: 17'h00009, nres: 5,
                res: mk5(QV1,QN,QN,QV1,node(0,1,2,3))};
    vecs[3] = '{a: mk5(node(1,2,3,4),QN,QN,QN,QN), b: mk5(QV0,QN,QN,QN,QN), c: mk5(QN,QN,QN,QN,QN),
                la: 5, lb: 1, lc: 1, gap: 0, frames: 5, exp_o: 17'h00009, nres: 5,
                res: mk5(QN,QN,QN,QN,QN)};
    vecs[4] = vecs[2];
    vecs[4].gap = 3;
    vecs[5] = '{a: mk5(QER,QN,QN,QN,QN), b: mk5(QN,QN,QN,QN,QN), c: mk5(QN,QN,QN,QN,QN),
                la: 1, lb: 1, lc: 1, gap: 0, frames: 1, exp_o: 17'h00001, nres: 1,
                res: mk5(QN,QN,QN,QN,QN)};
    vecs[6] = '{a: mk5(node(1,2,3,4),QV1,QV1,QV1,QV1), b: mk5(QN,QN,QN,QN,QN), c: mk5(QN,QN,QN,QN,QN),
                la: 5, lb: 1, lc: 1, gap: 0, frames: 5, exp_o: 17'h00009, nres: 5,
                res: mk5(QV1,QV1,QV1,QV1,QV1)};
    vecs[7] = '{a: mk5(node(1,2,3,4),QV1,QN,QN,QN), b: mk5(QV1,QN,QN,QN,QN), c: mk5(QN,QN,QN,QN,QN),
                la: 5, lb: 1, lc: 1, gap: 0, frames: 1, exp_o: 17'h00001, nres: 1,
                res: mk5(QV1,QN,QN,QN,QN)};

    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;
    bus.i_tvalid = 1'b0;
    bus.o_tready = 1'b0;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    chk("reset.o", bus.o_tdata, 67'd0);
    chk("reset.rdy", bus.i_tready, 67'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort mid-compute, then a fresh job must run cleanly
    load_tree(vecs[2].a, vecs[2].la, 0);
    load_tree(vecs[2].b, vecs[2].lb, 0);
    load_tree(vecs[2].c, vecs[2].lc, 0);
    repeat (4) @(negedge clk);
    chk("mid.busy_rdy", bus.i_tready, 67'd0);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    chk("mid_rst.o", bus.o_tdata, 67'd0);
    chk("mid_rst.rdy", bus.i_tready, 67'd1);
    run_vec(vecs[0], "after_rst");

    // operand A one word longer than its memory
    sb_q.push_back(17'h1FFFF);
    for (int i = 0; i < 1025; i++) send(QN, i == 1024);
    send(QN, 1'b1);
    send(QN, 1'b1);
    finish_vec("load_ovf", 0, 0, mk5(QN,QN,QN,QN,QN));

    run_vec(vecs[2], "post_ovf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
